// File: rtl/time_counter.sv
// BCD hh:mm:ss timekeeping core with hour/minute set mode and day-rollover pulse.
// Optional feature: define ALARM_EN to enable the registered alarm-match flag.
module time_counter #(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       time_clock,
  input  logic       time_reset,
  input  logic       time_tick,
  input  logic       time_mode,
  input  logic       time_inc,
  input  logic [7:0] time_alarm_hh,
  input  logic [7:0] time_alarm_mm,
  output logic [7:0] time_hh,
  output logic [7:0] time_mm,
  output logic [7:0] time_ss,
  output logic [1:0] time_edit,
  output logic       time_day,
  output logic       time_alarm
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  localparam logic [7:0] RESET_HH_BCD = {4'(RESET_HOUR / 10), 4'(RESET_HOUR % 10)};
  localparam logic [7:0] RESET_MM_BCD = {4'(RESET_MIN / 10), 4'(RESET_MIN % 10)};

  state_t     state_q, state_n;
  logic [7:0] hh_n, mm_n, ss_n;
  logic       day_n;

  // Increments a two-digit BCD value, wrapping to 00 once it equals max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_n = state_q;
    hh_n    = time_hh;
    mm_n    = time_mm;
    ss_n    = time_ss;
    day_n   = 1'b0;
    if (time_mode) begin
      // Mode wins: any tick or inc in the same cycle is dropped.
      unique case (state_q)
        RUN:      begin state_n = SET_HOUR; ss_n = 8'h00; end
        SET_HOUR: state_n = SET_MIN;
        default:  begin state_n = RUN; ss_n = 8'h00; end
      endcase
    end else begin
      unique case (state_q)
        RUN: if (time_tick) begin
          ss_n = bcd_inc(time_ss, 8'h59);
          if (time_ss == 8'h59) begin
            mm_n = bcd_inc(time_mm, 8'h59);
            if (time_mm == 8'h59) begin
              hh_n  = bcd_inc(time_hh, 8'h23);
              day_n = (time_hh == 8'h23);
            end
          end
        end
        SET_HOUR: if (time_inc) hh_n = bcd_inc(time_hh, 8'h23);
        default:  if (time_inc) mm_n = bcd_inc(time_mm, 8'h59);
      endcase
    end
  end

  always_ff @(posedge time_clock or negedge time_reset) begin
    if (!time_reset) begin
      state_q <= RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_n;
    end
  end

  always_ff @(posedge time_clock or negedge time_reset) begin
    if (!time_reset) begin
      time_hh  <= RESET_HH_BCD;
      time_mm  <= RESET_MM_BCD;
      time_ss  <= 8'h00;
      time_day <= 1'b0;
    end else begin
      time_hh  <= hh_n;
      time_mm  <= mm_n;
      time_ss  <= ss_n;
      time_day <= day_n;
    end
  end

  assign time_edit = state_q;

`ifdef ALARM_EN
  // Compares the registered time, so the flag trails the minute register by one cycle.
  always_ff @(posedge time_clock or negedge time_reset) begin
    if (!time_reset)
      time_alarm <= 1'b0;
    else
      time_alarm <= (state_q == RUN) && (time_hh == time_alarm_hh) &&
                    (time_mm == time_alarm_mm);
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{time_alarm_hh, time_alarm_mm};
  assign time_alarm   = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: an integer reference model pushes expected
// outputs to a scoreboard queue each cycle; they are popped and compared after the edge.
module tb_time_counter;

  localparam int RH = 12;
  localparam int RM = 34;
  localparam int AH = 7;
  localparam int AM = 30;
`ifdef ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic       time_clock = 1'b0;
  logic       time_reset = 1'b0;
  logic       time_tick = 1'b0, time_mode = 1'b0, time_inc = 1'b0;
  logic [7:0] time_alarm_hh = 8'h07, time_alarm_mm = 8'h30;
  logic [7:0] time_hh, time_mm, time_ss;
  logic [1:0] time_edit;
  logic       time_day, time_alarm;

  time_counter #(.RESET_HOUR(RH), .RESET_MIN(RM)) dut (
    .time_clock(time_clock), .time_reset(time_reset), .time_tick(time_tick),
    .time_mode(time_mode), .time_inc(time_inc), .time_alarm_hh(time_alarm_hh),
    .time_alarm_mm(time_alarm_mm), .time_hh(time_hh), .time_mm(time_mm),
    .time_ss(time_ss), .time_edit(time_edit), .time_day(time_day),
    .time_alarm(time_alarm)
  );

  always #5 time_clock = ~time_clock;

  typedef struct {
    logic [7:0] hh, mm, ss;
    logic [1:0] edit;
    logic       day, alarm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, kept in plain binary.
  int m_st = 0, m_h = RH, m_m = RM, m_s = 0;
  bit m_day = 1'b0, m_alarm = 1'b0;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_h = RH; m_m = RM; m_s = 0; m_day = 1'b0; m_alarm = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance model, push expectation, compare after edge.
  task automatic step(input bit tick, input bit mode, input bit inc);
    exp_t e, g;
    @(negedge time_clock);
    time_tick = tick; time_mode = mode; time_inc = inc;
    m_alarm = ALARM && (m_st == 0) && (m_h == AH) && (m_m == AM);
    m_day   = 1'b0;
    if (mode) begin
      if (m_st == 0)      begin m_st = 1; m_s = 0; end
      else if (m_st == 1) m_st = 2;
      else                begin m_st = 0; m_s = 0; end
    end else if (m_st == 0 && tick) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0; m_m++;
        if (m_m == 60) begin
          m_m = 0; m_h++;
          if (m_h == 24) begin m_h = 0; m_day = 1'b1; end
        end
      end
    end else if (m_st == 1 && inc) begin
      m_h = (m_h + 1) % 24;
    end else if (m_st == 2 && inc) begin
      m_m = (m_m + 1) % 60;
    end
    e.hh = bcd(m_h); e.mm = bcd(m_m); e.ss = bcd(m_s);
    e.edit = 2'(m_st); e.day = m_day; e.alarm = m_alarm;
    sb_q.push_back(e);
    @(posedge time_clock);
    #1;
    time_tick = 1'b0; time_mode = 1'b0; time_inc = 1'b0;
    g = sb_q.pop_front();
    check("hh", 32'(time_hh), 32'(g.hh));
    check("mm", 32'(time_mm), 32'(g.mm));
    check("ss", 32'(time_ss), 32'(g.ss));
    check("edit", 32'(time_edit), 32'(g.edit));
    check("day", 32'(time_day), 32'(g.day));
    check("alarm", 32'(time_alarm), 32'(g.alarm));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Enter set mode, dial in h:m, return to RUN (ss ends at 00).
  task automatic set_time(input int h, input int m);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 24 && m_h != h; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && m_m != m; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hh"}, 32'(time_hh), 32'(bcd(RH)));
    check({tag, "_mm"}, 32'(time_mm), 32'(bcd(RM)));
    check({tag, "_ss"}, 32'(time_ss), 32'h0);
    check({tag, "_edit"}, 32'(time_edit), 32'h0);
    check({tag, "_day"}, 32'(time_day), 32'h0);
    check({tag, "_alarm"}, 32'(time_alarm), 32'h0);
  endtask

  initial begin
    // 1. Reset values, then five ticks.
    repeat (3) @(posedge time_clock);
    #1 check_reset_values("rst");
    @(negedge time_clock);
    time_reset = 1'b1;
    ticks(5);

    // 2. Day wrap and carry across tens of hours.
    set_time(23, 59);
    for (int i = 0; i < 58; i++) step(1'b1, 1'b0, 1'b0);
    ticks(2);
    step(1'b0, 1'b0, 1'b0);
    set_time(9, 59);
    for (int i = 0; i < 59; i++) step(1'b1, 1'b0, 1'b0);
    ticks(1);

    // 3. Set-mode sequence with field wraps and ignored ticks.
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 24 && m_h != 22; i++) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && m_m != 58; i++) step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    ticks(2);
    step(1'b1, 1'b0, 1'b1);

    // 4. Simultaneous events: mode beats tick and inc.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // 5. Asynchronous reset mid SET_MIN, between clock edges.
    @(negedge time_clock);
    #2 time_reset = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge time_clock);
    time_reset = 1'b1;
    ticks(1);

    // 6. Alarm window around 07:30 (stays 0 when the feature is compiled out).
    set_time(AH, AM - 1);
    for (int i = 0; i < 59; i++) step(1'b1, 1'b0, 1'b0);
    ticks(61);
    set_time(AH, AM);
    ticks(2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
